// File: rtl/iter_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter behind valid/ready handshakes, one bit position per clock.
// Optional macro ITER_SHIFTER_QUAD_STEP_EN: move four positions per clock while at least four remain.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt5,
    input  logic [1:0]       sh,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

`ifdef ITER_SHIFTER_QUAD_STEP_EN
    localparam logic QUAD_EN = 1'b1;
`else
    localparam logic QUAD_EN = 1'b0;
`endif

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_FOUR = CNT_ONE << 2'd2;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] y_next_s;
    logic [SHW-1:0]   count_r;
    logic [SHW-1:0]   count_next_s;
    logic [1:0]       op_r;
    logic [1:0]       op_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input logic [1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = {v[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, v[WIDTH-1:1]};
            2'b10:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            2'b11:   r = {v[0], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] step4(input logic [WIDTH-1:0] v, input logic [1:0] op);
        return step1(step1(step1(step1(v, op), op), op), op);
    endfunction

    // Next-state, operand capture and per-cycle shift step.
    always_comb begin
        state_next_s = state_r;
        y_next_s     = y_r;
        count_next_s = count_r;
        op_next_s    = op_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    y_next_s     = a;
                    count_next_s = shamt5;
                    op_next_s    = sh;
                    if (shamt5 != CNT_ZERO) begin
                        state_next_s = SHIFT;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (QUAD_EN && (count_r >= CNT_FOUR)) begin
                    y_next_s     = step4(y_r, op_r);
                    count_next_s = count_r - CNT_FOUR;
                end else begin
                    y_next_s     = step1(y_r, op_r);
                    count_next_s = count_r - CNT_ONE;
                end
                // The last step lands the count on zero, whichever step size took it there.
                if (count_next_s == CNT_ZERO) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags are decoded from the next state so they leave flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            y_r         <= {WIDTH{1'b0}};
            count_r     <= CNT_ZERO;
            op_r        <= 2'b00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            y_r         <= y_next_s;
            count_r     <= count_next_s;
            op_r        <= op_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign y         = y_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_iter_shifter.sv
// Table-driven plus randomized scoreboard bench for iter_shifter against a whole-word shift model.
// Honours ITER_SHIFTER_QUAD_STEP_EN for the expected latency.
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [4:0]  shamt5;
    logic [1:0]  sh;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    iter_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shamt5    (shamt5),
        .sh        (sh),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [4:0]  amt;
        logic [1:0]  sh;
        logic [31:0] y;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        int          lat;
        int          acc;
    } exp_t;

    localparam int NV = 12;
    vec_t        tbl[NV];
    exp_t        sb[$];
    logic [31:0] cur_exp = 32'd0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          n_acc   = 0;
    int          last_acc = 0;
    int          last_hs  = 0;
    logic        prev_ov  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] n, input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00:   r = v << n;
            2'b01:   r = v >> n;
            2'b10:   r = 32'($signed(v) >>> n);
            default: r = (n == 5'd0) ? v : ((v >> n) | (v << (6'd32 - {1'b0, n})));
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [4:0] n);
`ifdef ITER_SHIFTER_QUAD_STEP_EN
        return int'(n >> 2) + int'(n & 5'd3) + 1;
`else
        return int'(n) + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept monitor: every handshake on the input side pushes its expectation.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            sb.push_back('{cur_exp, exp_lat(shamt5), cyc + 1});
            n_acc    <= n_acc + 1;
            last_acc <= cyc + 1;
        end
    end

    // Output monitor: latency on rising out_valid, stable y while held, pop on handshake.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'(sb.size()), 32'd1);
            end else begin
                if (!prev_ov) begin
                    check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                end
                check("y_result", y, sb[0].y);
                if (out_ready) begin
                    void'(sb.pop_front());
                    last_hs <= cyc + 1;
                end
            end
        end
        prev_ov <= out_valid;
    end

    task automatic run_op(input logic [31:0] ta, input logic [4:0] tn, input logic [1:0] ts,
                          input logic [31:0] ty, input int hold);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            step();
            k++;
        end
        check("idle_before_op", 32'(in_ready), 32'd1);
        a = ta; shamt5 = tn; sh = ts; cur_exp = ty;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        a = $urandom; shamt5 = 5'($urandom); sh = 2'($urandom);
        k = 0;
        while (!out_valid && k < 100) begin
            step();
            k++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("y_retained", y, ty);
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        int acc0;
        logic [31:0] ra;
        logic [4:0]  rn;
        logic [1:0]  rs;

        tbl[0]  = '{32'h0000_0005, 5'd2,  2'b00, 32'h0000_0014, 0};
        tbl[1]  = '{32'h0000_0005, 5'd2,  2'b01, 32'h0000_0001, 0};
        tbl[2]  = '{32'h8000_0004, 5'd2,  2'b10, 32'hE000_0001, 0};
        tbl[3]  = '{32'h0000_0005, 5'd2,  2'b11, 32'h4000_0001, 0};
        tbl[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 0};
        tbl[5]  = '{32'h1234_5678, 5'd31, 2'b00, 32'h0000_0000, 5};
        tbl[6]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 0};
        tbl[7]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1};
        tbl[8]  = '{32'h0000_0001, 5'd31, 2'b11, 32'h0000_0002, 0};
        tbl[9]  = '{32'h1234_5678, 5'd4,  2'b11, 32'h8123_4567, 0};
        tbl[10] = '{32'h7FFF_FFFF, 5'd3,  2'b10, 32'h0FFF_FFFF, 2};
        tbl[11] = '{32'hF000_0000, 5'd0,  2'b10, 32'hF000_0000, 3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; shamt5 = 5'd0; sh = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", y, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].a, tbl[i].amt, tbl[i].sh, tbl[i].y, tbl[i].hold);
        end

        // Reset in the middle of a long shift.
        a = 32'd1; shamt5 = 5'd20; sh = 2'b00; cur_exp = 32'h0010_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_y", y, 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (30) step();
        check("midrst_no_pulse", 32'(out_valid), 32'd0);

        // Back-to-back: second request held high through the first operation.
        acc0 = n_acc;
        a = 32'h0000_00F0; shamt5 = 5'd3; sh = 2'b01; cur_exp = 32'h0000_001E;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        a = 32'h8000_0001; shamt5 = 5'd1; sh = 2'b11; cur_exp = 32'hC000_0000;
        check("b2b_in_ready_busy", 32'(in_ready), 32'd0);
        k = 0;
        while ((n_acc - acc0) < 2 && k < 100) begin
            step();
            k++;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc - acc0), 32'd2);
        check("b2b_accept_gap", 32'(last_acc - last_hs), 32'd1);
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            step();
            k++;
        end
        check("b2b_drained", 32'(sb.size()), 32'd0);
        check("b2b_total_accepts", 32'(n_acc - acc0), 32'd2);
        out_ready = 1'b0;
        step();

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rn = 5'($urandom);
            rs = 2'($urandom);
            run_op(ra, rn, rs, ref_shift(ra, rn, rs), (i % 7 == 0) ? 2 : 0);
        end

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            step();
            k++;
        end
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
